imul_share_arbiter: RTL and testbench
=====================================

# imul_share_arbiter

Sequences and shares one fixed-latency integer multiplier (64-bit operand-pair request, 32-bit product response, val/rdy on both sides) among `p_nreqs` requesters. It sits between the requester ports and a single multiplier instance. Requesters are granted in round-robin order, one transaction at a time. Each product is routed back to the requester that issued it.

## Interface
- `p_nreqs`, default 4: number of requesters, legal range 2..8.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `req_val` input, `p_nreqs` bits: per-requester request valid.
- `req_rdy` output, `p_nreqs` bits: per-requester request ready.
- `req_msg` input, `p_nreqs*64` bits: lane i is `[64i+63:64i]`. Bits {a[63:32], b[31:0]}.
- `resp_val` output, `p_nreqs` bits: per-requester response valid.
- `resp_rdy` input, `p_nreqs` bits: per-requester response ready.
- `resp_msg` output, `p_nreqs*32` bits: lane i is `[32i+31:32i]`. Carries the product.
- `mul_istream_val` output, 1 bit: request to the multiplier.
- `mul_istream_rdy` input, 1 bit: multiplier ready for a request.
- `mul_istream_msg` output, 64 bits: operands forwarded to the multiplier.
- `mul_ostream_val` input, 1 bit: multiplier result valid.
- `mul_ostream_rdy` output, 1 bit: arbiter ready for the multiplier result.
- `mul_ostream_msg` input, 32 bits: multiplier result.
- `stat_ntrans` output, 16 bits: count of completed transactions. Wraps modulo 2^16.

## Operation
- **Handshakes.** A handshake fires on a cycle where val && rdy. No val depends combinationally on the matching rdy.
- **State machine.** States are IDLE, ISSUE and WAIT. There is at most one transaction in flight.
- **IDLE.**
  - All outputs are deasserted.
  - If any `req_val` bit is set, the arbiter latches `grant` and moves to ISSUE.
  - `grant` is the first set bit at or after `ptr`, scanning upward modulo `p_nreqs`.
- **ISSUE.**
  - `mul_istream_val` = `req_val[grant]`.
  - `mul_istream_msg` = lane `grant` of `req_msg`.
  - `req_rdy[grant]` = `mul_istream_rdy`. All other `req_rdy` bits are 0.
  - When the multiplier request fires, the arbiter moves to WAIT.
  - `grant` is held throughout ISSUE. A higher-priority requester arriving during ISSUE never changes it.
- **WAIT.**
  - `resp_val[grant]` = `mul_ostream_val`. All other `resp_val` bits are 0.
  - `mul_ostream_rdy` = `resp_rdy[grant]`.
  - Every `resp_msg` lane carries `mul_ostream_msg`. Only the `grant` lane has its val set.
  - When the response fires, the arbiter does three things:
    - sets `ptr` = (`grant`+1) mod `p_nreqs`;
    - increments `stat_ntrans`;
    - returns to IDLE.
- **Requester stall.** A requester holding `resp_rdy` low stalls the arbiter in WAIT indefinitely. Other requesters are not served meanwhile.
- **Requester obligations.** Once `req_val` is asserted, `req_val` and `req_msg` must stay stable until the request fires.
- **Reset.** Synchronous reset has the following effects:
  - state = IDLE;
  - `ptr` = 0;
  - `grant` = 0;
  - `stat_ntrans` = 0;
  - all val/rdy outputs = 0.
- **Reset mid-transaction.** Any in-flight transaction is abandoned. The multiplier shares the same reset, so no stale response is ever routed.

## Timing
- Request to multiplier: the first request seen in IDLE at cycle t is presented to the multiplier at cycle t+1 at the earliest.
- Response path: combinational passthrough with zero added latency.
- Back-to-back transactions: the next IDLE cycle follows the response fire. The minimum gap between successive multiplier requests is 2 cycles plus the multiplier latency.
- Fairness: under continuous requests from all requesters, each requester receives exactly one grant per `p_nreqs` transactions.

## Structure
- **Package `imul_share_pkg`** holds:
  - the state enum {IDLE, ISSUE, WAIT};
  - message width constants (64 for requests, 32 for responses);
  - the `p_nreqs` limit (8).
- **Sub-module `imul_rr_picker`**: combinational. Its inputs are `req_val` and `ptr`. Its outputs are the one-hot grant and the encoded grant index, of width `$clog2(p_nreqs)`.
- **Top level** contains the FSM, the `grant`/`ptr`/`stat_ntrans` registers, and the lane muxes.

## Test plan
- **Single request.** With `p_nreqs`=4, requester 2 sends a=3, b=4.
  - Requester 2 receives `resp_msg` lane 2 = 12 with only `resp_val[2]`=1.
  - `stat_ntrans` = 1.
- **Simultaneous requests, round-robin order.** All four requesters assert at once with operands (i+1, 10) for requester i.
  - Responses arrive in the order 0, 1, 2, 3 with values 10, 20, 30, 40.
  - The final `ptr` = 0.
- **Pointer wrap.** `ptr` = 3 after a transaction from requester 2. Requesters 0 and 3 then request together.
  - Requester 3 is served first, then requester 0.
- **Response backpressure.** The owner holds `resp_rdy` low for 20 cycles with a=-2 (0xFFFFFFFE), b=5.
  - The arbiter stays in WAIT, with `mul_ostream_rdy`=0 and no new `mul_istream_val`.
  - After release, the response is 0xFFFFFFF6.
- **Late arrival during ISSUE.** Requester 3 is granted. Requester 1 (higher priority given `ptr`=0) asserts during ISSUE.
  - The grant stays on requester 3.
  - Requester 1 is served next.
- **Reset mid-WAIT.** Assert reset for 1 cycle during WAIT.
  - All val/rdy outputs become 0, `stat_ntrans` = 0, and no response is delivered.
  - A subsequent request 7×6 returns 42.

Source files
------------

// File: rtl/imul_share_pkg.sv
// Shared types and constants for the shared integer-multiplier arbiter.
package imul_share_pkg;

  localparam int unsigned REQ_W     = 64;
  localparam int unsigned RESP_W    = 32;
  localparam int unsigned MAX_NREQS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // Operand pair as carried on a request lane
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } mul_req_t;

endpackage

// File: rtl/imul_rr_picker.sv
// Round-robin pick: first set req_val bit at or after ptr, scanning upward modulo p_nreqs.
module imul_rr_picker #(
  parameter int unsigned p_nreqs = 4,
  parameter int unsigned IDX_W   = $clog2(p_nreqs)
) (
  input  logic [p_nreqs-1:0] req_val,
  input  logic [IDX_W-1:0]   ptr,
  output logic [p_nreqs-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    j            = 0;
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      j = (32'(ptr) + k) % p_nreqs;
      if (!found && req_val[j]) begin
        found           = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/imul_share_arbiter.sv
// Shares one fixed-latency multiplier among p_nreqs requesters, one transaction
// in flight, round-robin grant, product routed back to the issuing requester.
module imul_share_arbiter
  import imul_share_pkg::*;
#(
  parameter int unsigned p_nreqs = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_nreqs-1:0]        req_val,
  output logic [p_nreqs-1:0]        req_rdy,
  input  logic [p_nreqs*REQ_W-1:0]  req_msg,
  output logic [p_nreqs-1:0]        resp_val,
  input  logic [p_nreqs-1:0]        resp_rdy,
  output logic [p_nreqs*RESP_W-1:0] resp_msg,
  output logic                      mul_istream_val,
  input  logic                      mul_istream_rdy,
  output logic [REQ_W-1:0]          mul_istream_msg,
  input  logic                      mul_ostream_val,
  output logic                      mul_ostream_rdy,
  input  logic [RESP_W-1:0]         mul_ostream_msg,
  output logic [15:0]               stat_ntrans
);

  localparam int unsigned IDX_W = $clog2(p_nreqs);

  state_t              state, state_next;
  logic [IDX_W-1:0]    grant, grant_next;
  logic [p_nreqs-1:0]  grant_oh, grant_oh_next;
  logic [IDX_W-1:0]    ptr, ptr_next;
  logic [15:0]         ntrans_next;
  logic [p_nreqs-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  mul_req_t            lane_req;

  imul_rr_picker #(
    .p_nreqs (p_nreqs),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_val      (req_val),
    .ptr          (ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_oh    <= '0;
      ptr         <= '0;
      stat_ntrans <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      grant_oh    <= grant_oh_next;
      ptr         <= ptr_next;
      stat_ntrans <= ntrans_next;
    end
  end

  assign lane_req = mul_req_t'(req_msg[32'(grant)*REQ_W +: REQ_W]);

  // Every response lane sees the product; only the owner's val is raised
  assign resp_msg = {p_nreqs{mul_ostream_msg}};

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    grant_oh_next   = grant_oh;
    ptr_next        = ptr;
    ntrans_next     = stat_ntrans;
    req_rdy         = '0;
    resp_val        = '0;
    mul_istream_val = 1'b0;
    mul_istream_msg = '0;
    mul_ostream_rdy = 1'b0;

    case (state)
      IDLE: begin
        if (|req_val) begin
          grant_next    = pick_idx;
          grant_oh_next = pick_onehot;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        mul_istream_val = |(req_val & grant_oh);
        mul_istream_msg = lane_req;
        req_rdy         = grant_oh & {p_nreqs{mul_istream_rdy}};
        if (mul_istream_val && mul_istream_rdy) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        resp_val        = grant_oh & {p_nreqs{mul_ostream_val}};
        mul_ostream_rdy = |(resp_rdy & grant_oh);
        if (mul_ostream_val && mul_ostream_rdy) begin
          ptr_next    = (grant == IDX_W'(p_nreqs - 1)) ? '0 : grant + IDX_W'(1);
          ntrans_next = stat_ntrans + 16'd1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imul_share_arbiter.sv
// Directed bench for imul_share_arbiter with a fixed-latency multiplier model.
module tb_imul_share_arbiter;

  localparam int unsigned N   = 4;
  localparam int          LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_val, req_rdy, resp_val, resp_rdy;
  logic [N*64-1:0]   req_msg;
  logic [N*32-1:0]   resp_msg;
  logic              mul_istream_val, mul_istream_rdy;
  logic [63:0]       mul_istream_msg;
  logic              mul_ostream_val, mul_ostream_rdy;
  logic [31:0]       mul_ostream_msg;
  logic [15:0]       stat_ntrans;

  int                checks = 0;
  int                failures = 0;
  int                log_idx[$];
  logic [31:0]       log_data[$];
  logic [N-1:0]      log_vec[$];
  logic              mbusy, mul_hold;
  int                mcnt;
  int                ival_seen, ordy_seen;

  imul_share_arbiter #(.p_nreqs(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .req_msg         (req_msg),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .resp_msg        (resp_msg),
    .mul_istream_val (mul_istream_val),
    .mul_istream_rdy (mul_istream_rdy),
    .mul_istream_msg (mul_istream_msg),
    .mul_ostream_val (mul_ostream_val),
    .mul_ostream_rdy (mul_ostream_rdy),
    .mul_ostream_msg (mul_ostream_msg),
    .stat_ntrans     (stat_ntrans)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, then update requesters and multiplier model
  task automatic tick();
    logic [N-1:0] req_f;
    logic         in_f, out_f;
    logic [31:0]  prod;
    @(negedge clk);
    req_f = req_val & req_rdy;
    in_f  = mul_istream_val && mul_istream_rdy;
    out_f = mul_ostream_val && mul_ostream_rdy;
    prod  = mul_istream_msg[63:32] * mul_istream_msg[31:0];
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (resp_val[i] && resp_rdy[i]) begin
          log_idx.push_back(i);
          log_data.push_back(resp_msg[i*32 +: 32]);
          log_vec.push_back(resp_val);
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      mbusy = 1'b0;
      mcnt = 0;
      mul_ostream_val = 1'b0;
    end else begin
      req_val = req_val & ~req_f;
      if (out_f) begin
        mul_ostream_val = 1'b0;
        mbusy = 1'b0;
      end
      if (in_f) begin
        mbusy = 1'b1;
        mcnt = LAT;
        mul_ostream_msg = prod;
      end else if (mbusy && !mul_ostream_val) begin
        mcnt--;
        if (mcnt == 0) mul_ostream_val = 1'b1;
      end
    end
    mul_istream_rdy = !mbusy && !mul_hold;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_data.delete();
    log_vec.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_val = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_msg[i*64 +: 64] = {a, b};
    req_val[i] = 1'b1;
  endtask

  task automatic wait_resp(input int n, input int budget, input string tag);
    int c = 0;
    while (log_idx.size() < n && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_count"}, log_idx.size(), n);
  endtask

  task automatic check_resp(input int k, input int idx, input logic [31:0] data, input string tag);
    if (k < log_idx.size()) begin
      check({tag, "_idx"}, log_idx[k], idx);
      check({tag, "_data"}, log_data[k], data);
    end else begin
      check({tag, "_missing"}, log_idx.size(), k + 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_val = '0;
    req_msg = '0;
    resp_rdy = '1;
    mbusy = 1'b0;
    mcnt = 0;
    mul_hold = 1'b0;
    mul_istream_rdy = 1'b1;
    mul_ostream_val = 1'b0;
    mul_ostream_msg = '0;
    do_reset();

    #1;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_istream_val", mul_istream_val, 0);
    check("rst_ostream_rdy", mul_ostream_rdy, 0);
    check("rst_ntrans", stat_ntrans, 0);

    // Single request from requester 2, with request latency
    set_req(2, 32'd3, 32'd4);
    #1;
    check("single_idle_ival", mul_istream_val, 0);
    tick();
    #1;
    check("single_issue_ival", mul_istream_val, 1);
    check("single_issue_msg", mul_istream_msg, {32'd3, 32'd4});
    check("single_req_rdy", req_rdy, 4'b0100);
    wait_resp(1, 20, "single");
    check_resp(0, 2, 32'd12, "single");
    if (log_vec.size() > 0) check("single_onehot", log_vec[0], 4'b0100);
    check("single_ntrans", stat_ntrans, 1);
    check("single_ptr", dut.ptr, 3);

    // Pointer wrap: ptr=3, requesters 0 and 3 together
    clear_log();
    set_req(0, 32'd4, 32'd4);
    set_req(3, 32'd5, 32'd3);
    wait_resp(2, 40, "wrap");
    check_resp(0, 3, 32'd15, "wrap0");
    check_resp(1, 0, 32'd16, "wrap1");
    check("wrap_ptr", dut.ptr, 1);

    // All four simultaneous from ptr=0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd10);
    wait_resp(4, 80, "rr");
    for (int i = 0; i < N; i++) check_resp(i, i, 32'((i + 1) * 10), $sformatf("rr%0d", i));
    check("rr_ptr", dut.ptr, 0);
    check("rr_ntrans", stat_ntrans, 4);

    // Late arrival during ISSUE does not steal the grant
    clear_log();
    mul_hold = 1'b1;
    set_req(3, 32'd5, 32'd5);
    tick();
    set_req(1, 32'd6, 32'd8);
    tick();
    #1;
    check("late_ival", mul_istream_val, 1);
    check("late_msg", mul_istream_msg, {32'd5, 32'd5});
    check("late_req_rdy_hold", req_rdy, 0);
    mul_hold = 1'b0;
    mul_istream_rdy = !mbusy;
    #1;
    check("late_req_rdy", req_rdy, 4'b1000);
    wait_resp(2, 40, "late");
    check_resp(0, 3, 32'd25, "late0");
    check_resp(1, 1, 32'd48, "late1");
    check("late_ptr", dut.ptr, 2);

    // Response backpressure from requester 2 while requester 0 waits
    clear_log();
    resp_rdy[2] = 1'b0;
    set_req(2, 32'hFFFF_FFFE, 32'd5);
    repeat (6) tick();
    set_req(0, 32'd2, 32'd3);
    ival_seen = 0;
    ordy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if (mul_istream_val) ival_seen++;
      if (mul_ostream_rdy) ordy_seen++;
    end
    check("bp_ival_seen", ival_seen, 0);
    check("bp_ordy_seen", ordy_seen, 0);
    check("bp_resp_val", resp_val, 4'b0100);
    check("bp_no_resp", log_idx.size(), 0);
    resp_rdy[2] = 1'b1;
    wait_resp(2, 40, "bp");
    check_resp(0, 2, 32'hFFFF_FFF6, "bp0");
    check_resp(1, 0, 32'd6, "bp1");
    check("bp_ntrans", stat_ntrans, 8);

    // Reset while waiting on a stalled response
    clear_log();
    resp_rdy[1] = 1'b0;
    set_req(1, 32'd9, 32'd9);
    repeat (6) tick();
    #1;
    check("rw_pre_resp_val", resp_val, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rw_req_rdy", req_rdy, 0);
    check("rw_resp_val", resp_val, 0);
    check("rw_ival", mul_istream_val, 0);
    check("rw_ordy", mul_ostream_rdy, 0);
    check("rw_ntrans", stat_ntrans, 0);
    resp_rdy[1] = 1'b1;
    repeat (10) tick();
    check("rw_no_resp", log_idx.size(), 0);
    set_req(0, 32'd7, 32'd6);
    wait_resp(1, 20, "rw_after");
    check_resp(0, 0, 32'd42, "rw_after");
    check("rw_after_ntrans", stat_ntrans, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
